microwave_cook_ctrl: RTL and testbench

- Cook-cycle sequencer for the microwave: owns the cook timer and decides when the magnetron runs.
- Takes keypad time entry, the start/stop/clear buttons (active-low) and door_closed.
- Counts MM:SS down in BCD and drives the magnetron enable, the display time and the done/pause indicators.
- Sits between the front-panel inputs and the magnetron/display blocks; all outputs are registered.

---
 rtl/microwave_cook_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_microwave_cook_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/microwave_cook_ctrl.sv
// Microwave cook-cycle sequencer: keypad MM:SS entry, BCD countdown,
// magnetron enable, door interlock and pause/done indication.
module microwave_cook_ctrl #(
  parameter int TICK_DIV  = 50_000_000,
  parameter int MAX_MIN_T = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        startn,
  input  logic        stopn,
  input  logic        clearn,
  input  logic        door_closed,
  input  logic        key_valid,
  input  logic [3:0]  key_digit,
  output logic        mag_on,
  output logic [15:0] time_bcd,
  output logic [2:0]  state,
  output logic        pausing,
  output logic        done
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_TOP = PW'(TICK_DIV - 1);
  localparam logic [3:0] MAXT = 4'(MAX_MIN_T);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COOK  = 3'd1,
    S_PAUSE = 3'd2,
    S_DONE  = 3'd3
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [15:0]   r_time;
  logic [15:0]   w_time_nx;
  logic [PW-1:0] r_presc;
  logic [PW-1:0] w_presc_nx;
  logic          r_startn_q;
  logic          r_mag_on;
  logic          r_pausing;
  logic          r_done;

  logic          w_start_ev;
  logic          w_tick;
  logic          w_zero;
  logic          w_final;
  logic          w_key_ok;
  logic [15:0]   w_time_dec;
  logic [15:0]   w_time_shift;

  // One-second BCD countdown with borrow through sec_u, sec_t, min_u, min_t
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [3:0] mt, mu, st, su;
    {mt, mu, st, su} = t;
    if (su != 4'd0) begin
      su = su - 4'd1;
    end else begin
      su = 4'd9;
      if (st != 4'd0) begin
        st = st - 4'd1;
      end else begin
        st = 4'd5;
        if (mu != 4'd0) begin
          mu = mu - 4'd1;
        end else begin
          mu = 4'd9;
          mt = mt - 4'd1;
        end
      end
    end
    return {mt, mu, st, su};
  endfunction

  assign w_start_ev   = r_startn_q & ~startn;
  assign w_tick       = (r_presc == PRESC_TOP);
  assign w_zero       = (r_time == 16'h0000);
  // A tick at 00:01 (or a stray 00:00) ends the cycle instead of wrapping
  assign w_final      = w_zero || (r_time == 16'h0001);
  assign w_time_dec   = w_final ? 16'h0000 : bcd_dec(r_time);
  assign w_key_ok     = key_valid && (key_digit <= 4'd9) &&
                        (r_time[11:8] <= MAXT);
  assign w_time_shift = {r_time[11:0], key_digit};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state, next time value and prescaler in priority order
  always_comb begin
    w_next     = r_state;
    w_time_nx  = r_time;
    w_presc_nx = '0;
    if (!clearn) begin
      w_next    = S_IDLE;
      w_time_nx = 16'h0000;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (!stopn) begin
            w_time_nx = 16'h0000;
          end else if (w_start_ev && door_closed && !w_zero) begin
            w_next = S_COOK;
          end else if (w_key_ok) begin
            w_time_nx = w_time_shift;
          end
        end
        S_COOK: begin
          w_presc_nx = w_tick ? '0 : r_presc + 1'b1;
          if (!door_closed) begin
            w_next     = S_PAUSE;
            w_presc_nx = '0;
            if (w_tick) w_time_nx = w_time_dec;
          end else if (!stopn) begin
            w_presc_nx = '0;
            if (w_tick && w_final) begin
              w_next    = S_IDLE;
              w_time_nx = 16'h0000;
            end else begin
              w_next = S_PAUSE;
              if (w_tick) w_time_nx = w_time_dec;
            end
          end else if (w_tick) begin
            w_time_nx = w_time_dec;
            if (w_final) w_next = S_DONE;
          end
        end
        S_PAUSE: begin
          if (!door_closed) begin
            w_next = S_PAUSE;
          end else if (!stopn) begin
            w_next    = S_IDLE;
            w_time_nx = 16'h0000;
          end else if (w_start_ev) begin
            w_next = S_COOK;
          end
        end
        S_DONE: begin
          w_time_nx = 16'h0000;
          if (!stopn || !door_closed) begin
            w_next = S_IDLE;
          end
        end
        default: begin
          w_next    = S_IDLE;
          w_time_nx = 16'h0000;
        end
      endcase
    end
  end

  // Datapath registers, start-edge history and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_time     <= 16'h0000;
      r_presc    <= '0;
      r_startn_q <= 1'b1;
      r_mag_on   <= 1'b0;
      r_pausing  <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_time     <= w_time_nx;
      r_presc    <= w_presc_nx;
      r_startn_q <= startn;
      r_mag_on   <= (w_next == S_COOK);
      r_pausing  <= (w_next == S_PAUSE);
      r_done     <= (w_next == S_DONE);
    end
  end

  assign mag_on   = r_mag_on;
  assign pausing  = r_pausing;
  assign done     = r_done;
  assign time_bcd = r_time;
  assign state    = r_state;

endmodule

// File: tb/tb_microwave_cook_ctrl.sv
// Directed bench for microwave_cook_ctrl with TICK_DIV=4 and
// hand-computed expected values.
module tb_microwave_cook_ctrl;

  logic        clk;
  logic        rst;
  logic        startn;
  logic        stopn;
  logic        clearn;
  logic        door_closed;
  logic        key_valid;
  logic [3:0]  key_digit;
  logic        mag_on;
  logic [15:0] time_bcd;
  logic [2:0]  state;
  logic        pausing;
  logic        done;

  int n_tests;
  int n_fail;

  microwave_cook_ctrl #(
    .TICK_DIV (4),
    .MAX_MIN_T(9)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .startn     (startn),
    .stopn      (stopn),
    .clearn     (clearn),
    .door_closed(door_closed),
    .key_valid  (key_valid),
    .key_digit  (key_digit),
    .mag_on     (mag_on),
    .time_bcd   (time_bcd),
    .state      (state),
    .pausing    (pausing),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [15:0] got,
                       input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [3:0] d);
    key_valid = 1'b1;
    key_digit = d;
    cyc(1);
    key_valid = 1'b0;
  endtask

  task automatic press_start();
    startn = 1'b0;
    cyc(1);
    startn = 1'b1;
  endtask

  task automatic do_clear();
    clearn = 1'b0;
    cyc(1);
    clearn = 1'b1;
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    rst         = 1'b1;
    startn      = 1'b1;
    stopn       = 1'b1;
    clearn      = 1'b1;
    door_closed = 1'b1;
    key_valid   = 1'b0;
    key_digit   = 4'd0;
    cyc(2);
    check("rst_state", 16'(state), 16'd0);
    check("rst_time", time_bcd, 16'h0000);
    check("rst_flags", {13'd0, mag_on, pausing, done}, 16'd0);
    rst = 1'b0;
    cyc(1);

    // entry 00:12 and full cook
    key(4'd0); key(4'd0); key(4'd1); key(4'd2);
    check("entry_12", time_bcd, 16'h0012);
    press_start();
    check("start_mag", 16'(mag_on), 16'd1);
    check("start_state", 16'(state), 16'd1);
    check("start_time", time_bcd, 16'h0012);
    cyc(4);
    check("tick1", time_bcd, 16'h0011);
    cyc(43);
    check("pre_done_time", time_bcd, 16'h0001);
    check("pre_done_state", 16'(state), 16'd1);
    cyc(1);
    check("done_time", time_bcd, 16'h0000);
    check("done_state", 16'(state), 16'd3);
    check("done_flags", {13'd0, mag_on, pausing, done}, 16'b001);

    // DONE ignores start; door open exits
    press_start();
    check("done_start_ign", 16'(state), 16'd3);
    door_closed = 1'b0;
    cyc(1);
    door_closed = 1'b1;
    check("done_exit_state", 16'(state), 16'd0);
    check("done_exit_flag", 16'(done), 16'd0);

    // borrow 01:00 -> 00:59, then clear in COOK
    key(4'd0); key(4'd1); key(4'd0); key(4'd0);
    check("entry_100", time_bcd, 16'h0100);
    press_start();
    cyc(4);
    check("borrow_59", time_bcd, 16'h0059);
    do_clear();
    check("clr_state", 16'(state), 16'd0);
    check("clr_time", time_bcd, 16'h0000);
    check("clr_mag", 16'(mag_on), 16'd0);

    // 00:70 counts down through 60 to 59
    key(4'd0); key(4'd0); key(4'd7); key(4'd0);
    press_start();
    cyc(4);
    check("s70_69", time_bcd, 16'h0069);
    cyc(36);
    check("s70_60", time_bcd, 16'h0060);
    cyc(4);
    check("s70_59", time_bcd, 16'h0059);
    do_clear();

    // door interlock at 00:07
    key(4'd0); key(4'd0); key(4'd0); key(4'd9);
    press_start();
    cyc(8);
    check("door_pre", time_bcd, 16'h0007);
    door_closed = 1'b0;
    cyc(1);
    check("door_state", 16'(state), 16'd2);
    check("door_mag", 16'(mag_on), 16'd0);
    check("door_pausing", 16'(pausing), 16'd1);
    check("door_hold", time_bcd, 16'h0007);
    press_start();
    check("door_start_ign", 16'(state), 16'd2);
    door_closed = 1'b1;
    cyc(1);
    press_start();
    check("resume_state", 16'(state), 16'd1);
    check("resume_time", time_bcd, 16'h0007);
    cyc(3);
    check("resume_3cyc", time_bcd, 16'h0007);
    cyc(1);
    check("resume_tick", time_bcd, 16'h0006);

    // stop -> PAUSE, second stop -> IDLE
    stopn = 1'b0;
    cyc(1);
    stopn = 1'b1;
    check("stop1_state", 16'(state), 16'd2);
    check("stop1_time", time_bcd, 16'h0006);
    cyc(1);
    stopn = 1'b0;
    cyc(1);
    stopn = 1'b1;
    check("stop2_state", 16'(state), 16'd0);
    check("stop2_time", time_bcd, 16'h0000);

    // start with zero time stays IDLE
    press_start();
    check("zero_start", 16'(state), 16'd0);

    // digit 0xA ignored; 5th digit shifts out min_t
    key(4'd5);
    key(4'hA);
    check("key_a_ign", time_bcd, 16'h0005);
    do_clear();
    key(4'd1); key(4'd2); key(4'd3); key(4'd4);
    check("entry_1234", time_bcd, 16'h1234);
    key(4'd5);
    check("shift_out", time_bcd, 16'h2345);
    do_clear();
    key(4'd5);

    // start held low after pause gives no restart
    press_start();
    door_closed = 1'b0;
    cyc(1);
    check("hold_pause", 16'(state), 16'd2);
    startn = 1'b0;
    cyc(1);
    door_closed = 1'b1;
    cyc(20);
    check("hold_state", 16'(state), 16'd2);
    check("hold_mag", 16'(mag_on), 16'd0);
    startn = 1'b1;
    cyc(1);

    // reset during COOK
    press_start();
    check("pre_rst_mag", 16'(mag_on), 16'd1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("cook_rst_state", 16'(state), 16'd0);
    check("cook_rst_time", time_bcd, 16'h0000);
    check("cook_rst_flags", {13'd0, mag_on, pausing, done}, 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
